// File: rtl/sfm_sched.sv
// -----------------------------------------------------------------------------
// sfm_sched -- softmax job scheduler.
//
// Sequences one softmax job over a vector of len_i elements packed LANES per
// stream beat:
//   1. accumulate pass: issue an input-streamer command and count beats while
//      the datapath builds its max/sum (mode 1),
//   2. request the reciprocal of the accumulated sum and wait for it,
//   3. normalize pass: issue input and output streamer commands together, then
//      count beats (mode 2) until the last beat is seen and the output streamer
//      reports that it has finished writing.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   clear_i                  synchronous abort (same as reset, keeps cycles_o)
//   start_i                  job start pulse (taken in IDLE only)
//   base_in_i / base_out_i   source / destination byte base address
//   len_i                    vector length in elements (0 -> empty job)
//   busy_o / done_o          job in flight / one-cycle completion pulse
//   in_cmd_*  / out_cmd_*    streamer command handshakes (addr, beat count)
//   beat_i                   datapath beat accepted this cycle
//   mode_o                   0 idle, 1 accumulate, 2 normalize
//   last_o / strb_o          last beat of the pass / lane strobe of the beat
//   inv_start_o, inv_done_i  reciprocal request / reciprocal ready
//   out_done_i               output streamer finished writing
//   cycles_o                 busy-cycle counter (only with SFM_SCHED_PERF_EN)
//
// Optional feature: define SFM_SCHED_PERF_EN to add the cycles_o port.
// -----------------------------------------------------------------------------

// Per-lane strobe: a lane is enabled on every beat of a pass, except on the
// last beat of a ragged vector where only lanes below the remainder carry data.
module sfm_sched_strb_lane #(
  parameter int LEN_WIDTH = 16,
  parameter int LANE      = 0
) (
  input  logic                 run_i,
  input  logic                 last_i,
  input  logic [LEN_WIDTH-1:0] rem_i,
  output logic                 strb_o
);
  localparam logic [LEN_WIDTH-1:0] LANE_L = LEN_WIDTH'(LANE);

  assign strb_o = run_i && (!last_i || (rem_i == '0) || (LANE_L < rem_i));
endmodule

module sfm_sched #(
  parameter  int DATA_WIDTH = 128,
  parameter  int WIDTH      = 16,
  parameter  int LEN_WIDTH  = 16,
  parameter  int ADDR_WIDTH = 32,
  localparam int LANES      = DATA_WIDTH / WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_in_i,
  input  logic [ADDR_WIDTH-1:0] base_out_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  in_cmd_valid_o,
  input  logic                  in_cmd_ready_i,
  output logic [ADDR_WIDTH-1:0] in_cmd_addr_o,
  output logic [LEN_WIDTH-1:0]  in_cmd_beats_o,
  output logic                  out_cmd_valid_o,
  input  logic                  out_cmd_ready_i,
  output logic [ADDR_WIDTH-1:0] out_cmd_addr_o,
  output logic [LEN_WIDTH-1:0]  out_cmd_beats_o,
  input  logic                  beat_i,
  output logic [1:0]            mode_o,
  output logic                  last_o,
  output logic [LANES-1:0]      strb_o,
  output logic                  inv_start_o,
  input  logic                  inv_done_i,
  input  logic                  out_done_i
`ifdef SFM_SCHED_PERF_EN
  ,
  output logic [31:0]           cycles_o
`endif
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ACC_CMD  = 3'd1;
  localparam logic [2:0] ACC_RUN  = 3'd2;
  localparam logic [2:0] INV      = 3'd3;
  localparam logic [2:0] NORM_CMD = 3'd4;
  localparam logic [2:0] NORM_RUN = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  localparam logic [LEN_WIDTH-1:0] LANES_L = LEN_WIDTH'(LANES);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_in_q, base_out_q;
  logic [LEN_WIDTH-1:0]  beats_q, rem_q, cnt_q;
  logic                  in_acc_q, out_acc_q;   // NORM_CMD command already taken
  logic                  odone_q;               // out_done_i seen in NORM_RUN
  logic                  inv_start_q, done_q;

  logic [LEN_WIDTH-1:0]  rem_calc, beats_calc;
  logic                  run, last, last_hs, beats_fin, in_ok, out_ok;
  logic                  start_job;

  // Beat count is ceil(len / LANES); remainder drives the last-beat strobe.
  assign rem_calc   = len_i % LANES_L;
  assign beats_calc = (len_i / LANES_L) + LEN_WIDTH'(rem_calc != '0);

  assign start_job = (state_q == IDLE) && start_i;
  assign run       = (state_q == ACC_RUN) || (state_q == NORM_RUN);
  assign last      = run && (cnt_q == beats_q - 1'b1);
  assign last_hs   = last && beat_i;
  // Counter parks at beats_q once the pass has seen all its beats.
  assign beats_fin = (cnt_q == beats_q) || last_hs;
  assign in_ok     = in_acc_q  || in_cmd_ready_i;
  assign out_ok    = out_acc_q || out_cmd_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_i) state_d = (len_i != '0) ? ACC_CMD : DONE;
      ACC_CMD:  if (in_cmd_ready_i) state_d = ACC_RUN;
      ACC_RUN:  if (last_hs) state_d = INV;
      INV:      if (inv_done_i) state_d = NORM_CMD;
      NORM_CMD: if (in_ok && out_ok) state_d = NORM_RUN;
      NORM_RUN: if (beats_fin && (odone_q || out_done_i)) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q     <= IDLE;
      base_in_q   <= '0;
      base_out_q  <= '0;
      beats_q     <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      in_acc_q    <= 1'b0;
      out_acc_q   <= 1'b0;
      odone_q     <= 1'b0;
      inv_start_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Reciprocal request lands on the first INV cycle.
      inv_start_q <= (state_q == ACC_RUN) && last_hs;
      // Completion pulse follows the DONE cycle.
      done_q      <= (state_q == DONE);

      if (start_job && (len_i != '0)) begin
        base_in_q  <= base_in_i;
        base_out_q <= base_out_i;
        beats_q    <= beats_calc;
        rem_q      <= rem_calc;
      end

      if (run) begin
        if (beat_i && (cnt_q != beats_q)) cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end

      if (state_q == NORM_CMD) begin
        if (in_cmd_ready_i)  in_acc_q  <= 1'b1;
        if (out_cmd_ready_i) out_acc_q <= 1'b1;
      end else begin
        in_acc_q  <= 1'b0;
        out_acc_q <= 1'b0;
      end

      if (state_q == NORM_RUN) begin
        if (out_done_i) odone_q <= 1'b1;
      end else begin
        odone_q <= 1'b0;
      end
    end
  end

  assign busy_o          = (state_q != IDLE);
  assign done_o          = done_q;
  assign inv_start_o     = inv_start_q;
  assign in_cmd_valid_o  = (state_q == ACC_CMD) || ((state_q == NORM_CMD) && !in_acc_q);
  assign out_cmd_valid_o = (state_q == NORM_CMD) && !out_acc_q;
  assign in_cmd_addr_o   = base_in_q;
  assign out_cmd_addr_o  = base_out_q;
  assign in_cmd_beats_o  = beats_q;
  assign out_cmd_beats_o = beats_q;
  assign last_o          = last;

  always_comb begin
    mode_o = 2'd0;
    case (state_q)
      ACC_RUN, INV: mode_o = 2'd1;
      NORM_RUN:     mode_o = 2'd2;
      default:      mode_o = 2'd0;
    endcase
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sfm_sched_strb_lane #(
      .LEN_WIDTH (LEN_WIDTH),
      .LANE      (l)
    ) u_lane (
      .run_i  (run),
      .last_i (last),
      .rem_i  (rem_q),
      .strb_o (strb_o[l])
    );
  end

`ifdef SFM_SCHED_PERF_EN
  // Busy-cycle counter; clear_i leaves it alone so an aborted job's time
  // stays visible, only rst_i or the next accepted start zero it.
  logic [31:0] cyc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q <= '0;
    end else if (start_job && !clear_i) begin
      cyc_q <= '0;
    end else if (busy_o && (cyc_q != '1)) begin
      cyc_q <= cyc_q + 1'b1;
    end
  end

  assign cycles_o = cyc_q;
`endif

endmodule

// File: tb/tb_sfm_sched.sv
// Directed bench for sfm_sched (default parameters: LANES = 8).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_sfm_sched;
  localparam int AW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1, clear_i = 1'b0, start_i = 1'b0;
  logic [AW-1:0] base_in_i = '0, base_out_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          busy_o, done_o;
  logic          in_cmd_valid_o, in_cmd_ready_i = 1'b0;
  logic [AW-1:0] in_cmd_addr_o, out_cmd_addr_o;
  logic [LW-1:0] in_cmd_beats_o, out_cmd_beats_o;
  logic          out_cmd_valid_o, out_cmd_ready_i = 1'b0;
  logic          beat_i = 1'b0;
  logic [1:0]    mode_o;
  logic          last_o;
  logic [7:0]    strb_o;
  logic          inv_start_o, inv_done_i = 1'b0, out_done_i = 1'b0;
`ifdef SFM_SCHED_PERF_EN
  logic [31:0]   cycles_o;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sfm_sched dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .clear_i         (clear_i),
    .start_i         (start_i),
    .base_in_i       (base_in_i),
    .base_out_i      (base_out_i),
    .len_i           (len_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .in_cmd_valid_o  (in_cmd_valid_o),
    .in_cmd_ready_i  (in_cmd_ready_i),
    .in_cmd_addr_o   (in_cmd_addr_o),
    .in_cmd_beats_o  (in_cmd_beats_o),
    .out_cmd_valid_o (out_cmd_valid_o),
    .out_cmd_ready_i (out_cmd_ready_i),
    .out_cmd_addr_o  (out_cmd_addr_o),
    .out_cmd_beats_o (out_cmd_beats_o),
    .beat_i          (beat_i),
    .mode_o          (mode_o),
    .last_o          (last_o),
    .strb_o          (strb_o),
    .inv_start_o     (inv_start_o),
    .inv_done_i      (inv_done_i),
    .out_done_i      (out_done_i)
`ifdef SFM_SCHED_PERF_EN
    ,
    .cycles_o        (cycles_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, " busy"},  busy_o, 0);
    chk({tag, " done"},  done_o, 0);
    chk({tag, " ivld"},  in_cmd_valid_o, 0);
    chk({tag, " ovld"},  out_cmd_valid_o, 0);
    chk({tag, " mode"},  mode_o, 0);
    chk({tag, " strb"},  strb_o, 0);
    chk({tag, " last"},  last_o, 0);
    chk({tag, " inv"},   inv_start_o, 0);
  endtask

  int n_in, n_out, n_done, n_busy, lim;

  initial begin
    step(); step();
    idle_outs("reset");
    chk("reset iaddr", in_cmd_addr_o, 0);
    rst_i = 1'b0;
    step();

    // ---- len=20, LANES=8: 3 beats, remainder 4 -> last strobe 0x0F ----
    in_cmd_ready_i = 1; out_cmd_ready_i = 1;
    base_in_i = 32'h1000; base_out_i = 32'h2000; len_i = 20; start_i = 1;
    step(); start_i = 0;
    chk("acc_cmd ivld",  in_cmd_valid_o, 1);
    chk("acc_cmd iaddr", in_cmd_addr_o, 32'h1000);
    chk("acc_cmd ibeat", in_cmd_beats_o, 3);
    chk("acc_cmd ovld",  out_cmd_valid_o, 0);
    chk("acc_cmd busy",  busy_o, 1);
    chk("acc_cmd mode",  mode_o, 0);
    step();
    chk("acc_run mode", mode_o, 1);
    chk("acc_run ivld", in_cmd_valid_o, 0);
    chk("acc_run strb", strb_o, 8'hFF);
    chk("acc_run last", last_o, 0);
    beat_i = 1;
    step(); chk("acc b1 last", last_o, 0);
    step();
    chk("acc b2 last", last_o, 1);
    chk("acc b2 strb", strb_o, 8'h0F);
    step(); beat_i = 0;
    chk("inv start", inv_start_o, 1);
    chk("inv mode",  mode_o, 1);
    chk("inv strb",  strb_o, 0);
    chk("inv last",  last_o, 0);
    step();
    chk("inv start2", inv_start_o, 0);
    chk("inv busy",   busy_o, 1);
    inv_done_i = 1;
    step(); inv_done_i = 0;
    chk("norm_cmd ivld",  in_cmd_valid_o, 1);
    chk("norm_cmd ovld",  out_cmd_valid_o, 1);
    chk("norm_cmd ibeat", in_cmd_beats_o, 3);
    chk("norm_cmd obeat", out_cmd_beats_o, 3);
    chk("norm_cmd iaddr", in_cmd_addr_o, 32'h1000);
    chk("norm_cmd oaddr", out_cmd_addr_o, 32'h2000);
    step();
    chk("norm_run mode", mode_o, 2);
    chk("norm_run ivld", in_cmd_valid_o, 0);
    chk("norm_run ovld", out_cmd_valid_o, 0);
    beat_i = 1;
    step(); step();
    chk("norm b2 last", last_o, 1);
    chk("norm b2 strb", strb_o, 8'h0F);
    step(); beat_i = 0;
    chk("norm wait busy", busy_o, 1);
    chk("norm wait last", last_o, 0);
    chk("norm wait done", done_o, 0);
    out_done_i = 1;
    step(); out_done_i = 0;
    chk("done st busy", busy_o, 1);
    chk("done st done", done_o, 0);
    step();
    chk("done pulse", done_o, 1);
    chk("done busy",  busy_o, 0);
    step();
    chk("done once", done_o, 0);

    // ---- len=0: straight to DONE, no commands ----
    len_i = 0; start_i = 1;
    step(); start_i = 0;
    chk("len0 busy", busy_o, 1);
    chk("len0 ivld", in_cmd_valid_o, 0);
    chk("len0 ovld", out_cmd_valid_o, 0);
    chk("len0 done early", done_o, 0);
    step();
    chk("len0 done", done_o, 1);
    chk("len0 idle", busy_o, 0);
    step();
    chk("len0 done once", done_o, 0);

    // ---- len=8: out ready late in NORM_CMD, out_done before last beat ----
    out_cmd_ready_i = 0;
    base_in_i = 32'h40; base_out_i = 32'h80; len_i = 8; start_i = 1;
    step(); start_i = 0;
    step(); beat_i = 1;
    step(); beat_i = 0; inv_done_i = 1;
    step(); inv_done_i = 0;
    n_in = 0; n_out = 0;
    for (int i = 0; i < 6; i++) begin
      if (in_cmd_valid_o)  n_in++;
      if (out_cmd_valid_o) n_out++;
      out_cmd_ready_i = (i == 5);
      step();
    end
    out_cmd_ready_i = 0;
    chk("late ivld cycles", n_in, 1);
    chk("late ovld cycles", n_out, 6);
    chk("late norm mode",   mode_o, 2);
    chk("late last",        last_o, 1);
    chk("late strb full",   strb_o, 8'hFF);
    out_done_i = 1;
    step(); out_done_i = 0;
    chk("early odone mode", mode_o, 2);
    chk("early odone done", done_o, 0);
    beat_i = 1;
    step(); beat_i = 0;
    chk("early odone dstate", busy_o, 1);
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done_o) n_done++;
    end
    chk("early odone pulses", n_done, 1);

    // ---- reset in NORM_RUN, then restart; stray start ignored ----
    in_cmd_ready_i = 1; out_cmd_ready_i = 1;
    base_in_i = 32'h300; base_out_i = 32'h400; len_i = 16; start_i = 1;
    step(); start_i = 0;
    beat_i = 1; inv_done_i = 1;
    lim = 0;
    while (mode_o != 2 && lim < 20) begin step(); lim++; end
    chk("reach norm_run", mode_o, 2);
    beat_i = 0; inv_done_i = 0; rst_i = 1;
    step(); rst_i = 0;
    idle_outs("midrst");
    chk("midrst beats", in_cmd_beats_o, 0);
    len_i = 20; start_i = 1;
    step(); start_i = 0;
    step();
    chk("rerun acc mode", mode_o, 1);
    len_i = 0; start_i = 1;
    step(); start_i = 0;
    chk("stray start beats", in_cmd_beats_o, 3);
    beat_i = 1; inv_done_i = 1; out_done_i = 1;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done_o) n_done++;
    end
    beat_i = 0; inv_done_i = 0; out_done_i = 0;
    chk("rerun done pulses", n_done, 1);
    chk("rerun idle", busy_o, 0);

    // ---- clear_i during ACC_RUN aborts without done ----
    len_i = 16; start_i = 1;
    step(); start_i = 0;
    step();
    chk("pre-clear mode", mode_o, 1);
    clear_i = 1;
    step(); clear_i = 0;
    idle_outs("clear");
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done_o) n_done++;
    end
    chk("clear no done", n_done, 0);

`ifdef SFM_SCHED_PERF_EN
    // ---- busy-cycle counter, len=8 with everything immediate: 6 busy cycles ----
    len_i = 8; start_i = 1;
    beat_i = 1; inv_done_i = 1; out_done_i = 1;
    step(); start_i = 0;
    n_busy = 0; lim = 0;
    while (!done_o && lim < 20) begin
      if (busy_o) n_busy++;
      step(); lim++;
    end
    beat_i = 0; inv_done_i = 0; out_done_i = 0;
    chk("perf done seen", done_o, 1);
    chk("perf busy count", n_busy, 6);
    chk("perf cycles", cycles_o, 6);
    step(); step(); step();
    chk("perf hold", cycles_o, 6);
    rst_i = 1;
    step(); rst_i = 0;
    chk("perf rst", cycles_o, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sfm_sched.md
SFM_SCHED -- requirements
Module: sfm_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, stream beat width in bits.
REQ-002 SHALL have parameter WIDTH, default 16, element width in bits; LANES = DATA_WIDTH/WIDTH.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, element-count width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 32, TCDM byte-address width.
REQ-005 clk_i  in  1  single clock; all logic on its rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 clear_i  in  1  synchronous soft clear (abort).
REQ-008 start_i  in  1  job start pulse.
REQ-009 base_in_i / base_out_i  in  ADDR_WIDTH each  source / destination base address.
REQ-010 len_i  in  LEN_WIDTH  vector length in elements.
REQ-011 busy_o  out  1  high in every state except IDLE.
REQ-012 done_o  out  1  one-cycle job-complete pulse.
REQ-013 in_cmd_valid_o, in_cmd_ready_i, in_cmd_addr_o [ADDR_WIDTH], in_cmd_beats_o [LEN_WIDTH]  input-streamer command handshake.
REQ-014 out_cmd_valid_o, out_cmd_ready_i, out_cmd_addr_o [ADDR_WIDTH], out_cmd_beats_o [LEN_WIDTH]  output-streamer command handshake.
REQ-015 beat_i  in  1  datapath input beat accepted (valid&ready) this cycle.
REQ-016 mode_o  out  2  datapath mode: 0 idle, 1 accumulate (max/sum), 2 normalize.
REQ-017 last_o / strb_o  out  1 / LANES  current beat is last of pass / lane strobe of current beat.
REQ-018 inv_start_o  out  1  pulse requesting reciprocal of accumulated sum; inv_done_i  in  1  reciprocal ready.
REQ-019 out_done_i  in  1  output streamer finished writing.

Function
REQ-020 SHALL implement states IDLE, ACC_CMD, ACC_RUN, INV, NORM_CMD, NORM_RUN, DONE.
REQ-021 IDLE: start_i with len_i!=0 SHALL latch base_in_i, base_out_i, len_i and go to ACC_CMD; start_i with len_i==0 SHALL go to DONE, no commands issued.
REQ-022 start_i outside IDLE SHALL be ignored.
REQ-023 Beats SHALL be ceil(len/LANES); remainder r = len mod LANES.
REQ-024 ACC_CMD: in_cmd_valid_o=1, addr=base_in, beats=computed; hold stable until in_cmd_ready_i, then ACC_RUN.
REQ-025 ACC_RUN/NORM_RUN: mode_o = 1/2; beat counter increments on beat_i; last_o=1 while counter==beats-1.
REQ-026 strb_o SHALL be all ones, except on the last beat with r!=0: lanes 0..r-1 only; strb_o=0 and last_o=0 outside RUN states.
REQ-027 beat_i on last beat of ACC_RUN SHALL go to INV, inv_start_o high exactly that transition cycle +1 (first INV cycle).
REQ-028 INV: wait inv_done_i, then NORM_CMD; mode_o=1 held in INV.
REQ-029 NORM_CMD: in cmd (addr base_in) and out cmd (addr base_out, same beats) both valid; each dropped individually on its own ready; go to NORM_RUN cycle after both accepted (same-cycle acceptance allowed).
REQ-030 out_done_i SHALL be latched any cycle in NORM_RUN; leave to DONE once last beat counted AND out_done seen (either order, or same cycle).
REQ-031 DONE: done_o=1 for one cycle, then IDLE.
REQ-032 beat_i outside RUN states SHALL be ignored.
REQ-033 clear_i SHALL behave exactly as rst_i (except REQ-039 counter), no done_o.

Reset
REQ-034 rst_i SHALL force IDLE next edge, all outputs 0, counters and latches 0.
REQ-035 Reset mid-job SHALL drop any pending command valid without waiting for ready.

Configuration
REQ-036 Macro SFM_SCHED_PERF_EN SHALL compile in port cycles_o out 32.
REQ-037 With it: cycles_o counts cycles with busy_o=1, zeroed on accepted start, holds value after DONE, saturates at all ones.
REQ-038 Without it: no port, no counter logic.
REQ-039 clear_i SHALL not zero cycles_o; rst_i SHALL.

Verification
REQ-040 LANES=8, len=20, immediate readies -> in cmd beats=3 twice, out cmd beats=3, last beat strb_o=0x0F, done_o after out_done_i.
REQ-041 len=0 start -> no cmd valids, done_o pulses 2 cycles after start, busy_o high one cycle.
REQ-042 NORM_CMD, in ready immediate, out ready after 5 cycles -> in_cmd_valid_o 1 cycle, out_cmd_valid_o 6 cycles, NORM_RUN entered after.
REQ-043 out_done_i pulse before last NORM beat -> done_o only after last beat_i, exactly once.
REQ-044 rst_i in NORM_RUN, then start_i during next job's ACC_RUN -> outputs 0 after reset; second start ignored, job completes normally.
REQ-045 SFM_SCHED_PERF_EN, len=8, all readies/dones immediate -> cycles_o equals busy_o high count, stable after DONE.
